// File: rtl/ob_pkg.sv
// Shared types for the conditional-order table: entry count, index/count widths,
// the command record and the issue FSM encoding.
package ob_pkg;

    localparam int CN_ENTRIES_N = 8;

    typedef logic [$clog2(CN_ENTRIES_N)-1:0]   cn_idx_t;
    typedef logic [$clog2(CN_ENTRIES_N+1)-1:0] cn_cnt_t;

    typedef struct packed {
        logic [7:0]  id;
        logic        side;
        logic [14:0] trig_px;
        logic [7:0]  qty;
    } cmd_t;

    typedef enum logic [0:0] {
        ISS_IDLE  = 1'b0,
        ISS_VALID = 1'b1
    } iss_state_t;

endpackage

// File: rtl/ob_cn_table_arb.sv
// N-way issue arbiter: fixed lowest-index priority by default, round-robin from a
// rotating pointer when OB_CN_TABLE_CTRL_RR_EN is defined.
module ob_cn_table_arb
    import ob_pkg::*;
#(
    parameter int N = CN_ENTRIES_N,
    localparam int IW = $clog2(N)
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    input  logic [IW-1:0] adv_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

`ifdef OB_CN_TABLE_CTRL_RR_EN
    logic [IW-1:0] ptr_r;

    // Scan downward from the farthest offset so the nearest request to the pointer wins
    always_comb begin
        gnt_idx = {IW{1'b0}};
        for (int i = N-1; i >= 0; i--) begin
            gnt_idx = req[IW'((int'(ptr_r) + i) % N)] ? IW'((int'(ptr_r) + i) % N) : gnt_idx;
        end
        gnt = (|req) ? (ONE_HOT0 << gnt_idx) : {N{1'b0}};
    end

    // Pointer moves just past the entry whose command was taken downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {IW{1'b0}};
        end else if (adv) begin
            ptr_r <= (adv_idx == IW'(N-1)) ? {IW{1'b0}} : adv_idx + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{clk, rst, adv, adv_idx};

    // Lowest-index request wins
    always_comb begin
        gnt_idx = {IW{1'b0}};
        for (int i = N-1; i >= 0; i--) begin
            gnt_idx = req[i] ? IW'(i) : gnt_idx;
        end
        gnt = (|req) ? (ONE_HOT0 << gnt_idx) : {N{1'b0}};
    end
`endif

endmodule

// File: rtl/ob_cn_table_ctrl.sv
// Conditional-order table controller: allocates entries, issues matured commands
// downstream and tracks occupancy. OB_CN_TABLE_CTRL_RR_EN selects round-robin issue.
module ob_cn_table_ctrl
    import ob_pkg::*;
#(
    parameter int N = CN_ENTRIES_N,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(N+1)
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  cmd_t          in_cmd,
    output logic          in_rdy,
    output logic [N-1:0]  al_vld_r,
    output cmd_t          al_cmd_r,
    output logic [N-1:0]  dl_vld_r,
    input  logic [N-1:0]  busy,
    input  logic [N-1:0]  mtr,
    input  cmd_t          cmd [N],
    output logic          out_vld_r,
    output cmd_t          out_cmd_r,
    input  logic          out_rdy,
    output logic [CW-1:0] cnt_r,
    output logic          full_r,
    output logic          empty_r
);

    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]  free_s;
    logic          acc_s;
    logic [IW-1:0] alloc_idx_s;
    logic [N-1:0]  cand_s;
    logic [N-1:0]  gnt_s;
    logic [IW-1:0] gnt_idx_s;
    logic [IW-1:0] idx_r;
    iss_state_t    state_r;
    iss_state_t    state_s;
    logic          load_s;
    logic          hs_s;
    logic [CW-1:0] cnt_nxt_s;

    // An entry allocated last cycle has not raised busy yet, so mask it explicitly
    assign free_s = ~busy & ~al_vld_r;
    assign in_rdy = |free_s;
    assign acc_s  = in_vld & in_rdy;
    assign cand_s = mtr & ~dl_vld_r;

    // Lowest-index free entry for allocation
    always_comb begin
        alloc_idx_s = {IW{1'b0}};
        for (int i = N-1; i >= 0; i--) begin
            alloc_idx_s = free_s[i] ? IW'(i) : alloc_idx_s;
        end
    end

    // Allocation pulse lasts one cycle; the broadcast command holds between allocations
    always_ff @(posedge clk) begin
        if (rst) begin
            al_vld_r <= {N{1'b0}};
            al_cmd_r <= cmd_t'(32'h0000_0000);
        end else if (acc_s) begin
            al_vld_r <= ONE_HOT0 << alloc_idx_s;
            al_cmd_r <= in_cmd;
        end else begin
            al_vld_r <= {N{1'b0}};
            al_cmd_r <= al_cmd_r;
        end
    end

    ob_cn_table_arb #(.N(N)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (cand_s),
        .adv     (hs_s),
        .adv_idx (idx_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Issue FSM next-state and control strobes
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        hs_s    = 1'b0;
        case (state_r)
            ISS_IDLE: begin
                if (|gnt_s) begin
                    load_s  = 1'b1;
                    state_s = ISS_VALID;
                end else begin
                    state_s = ISS_IDLE;
                end
            end
            ISS_VALID: begin
                if (out_rdy) begin
                    hs_s    = 1'b1;
                    state_s = ISS_IDLE;
                end else begin
                    state_s = ISS_VALID;
                end
            end
            default: state_s = ISS_IDLE;
        endcase
    end

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ISS_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Output command register, granted index and deallocate pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_r <= 1'b0;
            out_cmd_r <= cmd_t'(32'h0000_0000);
            idx_r     <= {IW{1'b0}};
            dl_vld_r  <= {N{1'b0}};
        end else begin
            dl_vld_r <= hs_s ? (ONE_HOT0 << idx_r) : {N{1'b0}};
            if (load_s) begin
                out_vld_r <= 1'b1;
                out_cmd_r <= cmd[gnt_idx_s];
                idx_r     <= gnt_idx_s;
            end else if (hs_s) begin
                out_vld_r <= 1'b0;
            end else begin
                out_vld_r <= out_vld_r;
            end
        end
    end

    // Occupancy next value: accept and handshake in the same cycle cancel
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({acc_s, hs_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Occupancy and its registered full/empty flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_nxt_s;
            full_r  <= (cnt_nxt_s == CW'(N));
            empty_r <= (cnt_nxt_s == {CW{1'b0}});
        end
    end

endmodule

// File: tb/tb_ob_cn_table_ctrl.sv
// Directed bench for ob_cn_table_ctrl with a small behavioural entry array.
// Expected grant order follows OB_CN_TABLE_CTRL_RR_EN when defined.
module tb_ob_cn_table_ctrl;
    import ob_pkg::*;

    localparam int N = CN_ENTRIES_N;

    logic         clk;
    logic         rst;
    logic         in_vld;
    cmd_t         in_cmd;
    logic         in_rdy;
    logic [N-1:0] al_vld_r;
    cmd_t         al_cmd_r;
    logic [N-1:0] dl_vld_r;
    logic [N-1:0] busy;
    logic [N-1:0] mtr;
    logic [N-1:0] mtr_drv;
    cmd_t         cmd [N];
    logic         out_vld_r;
    cmd_t         out_cmd_r;
    logic         out_rdy;
    logic [$clog2(N+1)-1:0] cnt_r;
    logic         full_r;
    logic         empty_r;

    logic [31:0]  exp_cmd [N];
    int           checks = 0;
    int           errors = 0;

    ob_cn_table_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_cmd    (in_cmd),
        .in_rdy    (in_rdy),
        .al_vld_r  (al_vld_r),
        .al_cmd_r  (al_cmd_r),
        .dl_vld_r  (dl_vld_r),
        .busy      (busy),
        .mtr       (mtr),
        .cmd       (cmd),
        .out_vld_r (out_vld_r),
        .out_cmd_r (out_cmd_r),
        .out_rdy   (out_rdy),
        .cnt_r     (cnt_r),
        .full_r    (full_r),
        .empty_r   (empty_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the entry array: busy/command latched on allocate, freed on deallocate
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                busy[i] <= 1'b0;
                cmd[i]  <= cmd_t'(32'h0000_0000);
            end else if (al_vld_r[i]) begin
                busy[i] <= 1'b1;
                cmd[i]  <= al_cmd_r;
            end else if (dl_vld_r[i]) begin
                busy[i] <= 1'b0;
            end
        end
    end

    assign mtr = mtr_drv & busy;

    function automatic logic [31:0] mk(input int k);
        return 32'hC0DE_0000 + (32'(k) * 32'h0001_0101);
    endfunction

    function automatic logic [31:0] oh(input int k);
        logic [31:0] v;
        v = 32'h0000_0000;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int idx, input logic [31:0] v);
        in_vld = 1'b1;
        in_cmd = v;
        step();
        chk("al_vld", 32'(al_vld_r), oh(idx));
        chk("al_cmd", al_cmd_r, v);
        exp_cmd[idx] = v;
        in_vld = 1'b0;
    endtask

    task automatic pair(input logic [N-1:0] m, input int g1, input int g2, input int cnt_exp);
        mtr_drv = m;
        out_rdy = 1'b1;
        step();
        chk("pair_vld1", 32'(out_vld_r), 32'd1);
        chk("pair_cmd1", out_cmd_r, exp_cmd[g1]);
        step();
        chk("pair_dl1", 32'(dl_vld_r), oh(g1));
        chk("pair_vld_drop", 32'(out_vld_r), 32'd0);
        step();
        chk("pair_cmd2", out_cmd_r, exp_cmd[g2]);
        chk("pair_dl_clear", 32'(dl_vld_r), 32'd0);
        mtr_drv = {N{1'b0}};
        step();
        chk("pair_dl2", 32'(dl_vld_r), oh(g2));
        out_rdy = 1'b0;
        step();
        chk("pair_cnt", 32'(cnt_r), 32'(cnt_exp));
    endtask

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_cmd  = cmd_t'(32'h0000_0000);
        out_rdy = 1'b0;
        mtr_drv = {N{1'b0}};
        step();
        step();
        rst = 1'b0;
        chk("rst_al_vld", 32'(al_vld_r), 32'd0);
        chk("rst_dl_vld", 32'(dl_vld_r), 32'd0);
        chk("rst_out_vld", 32'(out_vld_r), 32'd0);
        chk("rst_out_cmd", out_cmd_r, 32'd0);
        chk("rst_cnt", 32'(cnt_r), 32'd0);
        chk("rst_full", 32'(full_r), 32'd0);
        chk("rst_empty", 32'(empty_r), 32'd1);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);

        // Fill the table on consecutive cycles
        for (int k = 0; k < N; k++) begin
            accept(k, mk(k));
        end
        step();
        chk("fill_al_idle", 32'(al_vld_r), 32'd0);
        chk("fill_in_rdy", 32'(in_rdy), 32'd0);
        chk("fill_cnt", 32'(cnt_r), 32'd8);
        chk("fill_full", 32'(full_r), 32'd1);
        chk("fill_empty", 32'(empty_r), 32'd0);

        // Entry 3 matures with downstream always ready
        mtr_drv = 8'h08;
        out_rdy = 1'b1;
        step();
        chk("e3_vld", 32'(out_vld_r), 32'd1);
        chk("e3_cmd", out_cmd_r, mk(3));
        mtr_drv = 8'h00;
        step();
        chk("e3_dl", 32'(dl_vld_r), 32'h08);
        chk("e3_cnt", 32'(cnt_r), 32'd7);
        chk("e3_full", 32'(full_r), 32'd0);
        chk("e3_in_rdy_low", 32'(in_rdy), 32'd0);
        out_rdy = 1'b0;
        step();
        chk("e3_dl_clear", 32'(dl_vld_r), 32'd0);
        chk("e3_in_rdy_high", 32'(in_rdy), 32'd1);

        // Entry 2 matures while downstream stalls
        mtr_drv = 8'h04;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_vld", 32'(out_vld_r), 32'd1);
            chk("stall_cmd", out_cmd_r, mk(2));
            chk("stall_dl", 32'(dl_vld_r), 32'd0);
            step();
        end
        out_rdy = 1'b1;
        step();
        chk("stall_dl_pulse", 32'(dl_vld_r), 32'h04);
        chk("stall_cnt", 32'(cnt_r), 32'd6);
        out_rdy = 1'b0;
        mtr_drv = 8'h00;
        step();

        // Entries 1 and 5 matured together
`ifdef OB_CN_TABLE_CTRL_RR_EN
        pair(8'h22, 5, 1, 4);
`else
        pair(8'h22, 1, 5, 4);
`endif

        // Refill 1, 2, 3, 5 and contend 1 against 5 again
        accept(1, mk(8));
        accept(2, mk(9));
        accept(3, mk(10));
        accept(5, mk(11));
        step();
        chk("refill_cnt", 32'(cnt_r), 32'd8);
        chk("refill_full", 32'(full_r), 32'd1);
`ifdef OB_CN_TABLE_CTRL_RR_EN
        pair(8'h22, 5, 1, 6);
`else
        pair(8'h22, 1, 5, 6);
`endif
        pair(8'h0C, 2, 3, 4);

        // Accept and handshake in the same cycle at occupancy 4
        mtr_drv = 8'h01;
        out_rdy = 1'b1;
        step();
        chk("sim_vld", 32'(out_vld_r), 32'd1);
        chk("sim_cmd", out_cmd_r, mk(0));
        in_vld = 1'b1;
        in_cmd = mk(12);
        step();
        chk("sim_cnt", 32'(cnt_r), 32'd4);
        chk("sim_al", 32'(al_vld_r), 32'h02);
        chk("sim_dl", 32'(dl_vld_r), 32'h01);
        chk("sim_al_cmd", al_cmd_r, mk(12));
        exp_cmd[1] = mk(12);
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        mtr_drv = 8'h00;
        step();
        chk("sim_cnt_hold", 32'(cnt_r), 32'd4);
        chk("sim_empty", 32'(empty_r), 32'd0);

        // Reset while a command is waiting downstream
        mtr_drv = 8'h10;
        step();
        chk("rv_vld", 32'(out_vld_r), 32'd1);
        chk("rv_cmd", out_cmd_r, mk(4));
        rst = 1'b1;
        step();
        chk("rv_out_vld", 32'(out_vld_r), 32'd0);
        chk("rv_dl", 32'(dl_vld_r), 32'd0);
        chk("rv_cnt", 32'(cnt_r), 32'd0);
        chk("rv_empty", 32'(empty_r), 32'd1);
        chk("rv_full", 32'(full_r), 32'd0);
        rst     = 1'b0;
        mtr_drv = 8'h00;
        step();
        chk("rv_in_rdy", 32'(in_rdy), 32'd1);
        chk("rv_idle", 32'(out_vld_r), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
